// File: rtl/chip_test_sequencer.sv
// Vector-driven test sequencer: walks a chip's vector table in an external sync ROM, drives pins,
// samples after a settle time and counts masked mismatches. Optional macro: CHK_STOP_ON_FAIL_EN.
module chip_test_sequencer #(
    parameter int NPINS  = 16,
    parameter int VEC_AW = 5,
    parameter int SETTLE = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [3:0]        Chip_Sel,
    output logic [3:0]        Chip_Lat,
    output logic [VEC_AW-1:0] Vec_Addr,
    input  logic [NPINS-1:0]  Vec_Drive,
    input  logic [NPINS-1:0]  Vec_OE,
    input  logic [NPINS-1:0]  Vec_Expect,
    input  logic [NPINS-1:0]  Vec_Mask,
    input  logic              Vec_Last,
    input  logic [NPINS-1:0]  Pin_In,
    output logic [NPINS-1:0]  Pin_Out,
    output logic [NPINS-1:0]  Pin_OE,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [7:0]        Err_Cnt,
    output logic [VEC_AW-1:0] Fail_Vec
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]     CNT_INIT = CW'(SETTLE - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [VEC_AW-1:0] ADDR_ONE = VEC_AW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [CW-1:0]     cnt_r;
    logic [NPINS-1:0]  exp_r;
    logic [NPINS-1:0]  mask_r;
    logic              last_r;
    logic [NPINS-1:0]  mis_s;
    logic [7:0]        err_inc_s;
    logic              at_end_s;
    logic              stop_s;

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and sample-phase compare terms
    always_comb begin
        next_state_s = state_r;
        mis_s        = (Pin_In ^ exp_r) & mask_r & ~Pin_OE;
        err_inc_s    = (Err_Cnt == 8'hFF) ? 8'hFF : (Err_Cnt + 8'd1);
        at_end_s     = last_r || (Vec_Addr == {VEC_AW{1'b1}});
`ifdef CHK_STOP_ON_FAIL_EN
        stop_s       = at_end_s || (mis_s != {NPINS{1'b0}});
`else
        stop_s       = at_end_s;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (!Start) begin
                    next_state_s = state_r;
                end else if (Chip_Sel == 4'd0) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_FETCH:  next_state_s = ST_LOAD;
            ST_LOAD:   next_state_s = ST_SETTLE;
            ST_SETTLE: begin
                if (cnt_r == {CW{1'b0}}) begin
                    next_state_s = ST_SAMPLE;
                end else begin
                    next_state_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                if (stop_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Run datapath: latched chip, vector index, pin drive, settle count and result registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            Chip_Lat <= 4'd0;
            Vec_Addr <= {VEC_AW{1'b0}};
            Pin_Out  <= {NPINS{1'b0}};
            Pin_OE   <= {NPINS{1'b0}};
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Pass     <= 1'b0;
            Err_Cnt  <= 8'd0;
            Fail_Vec <= {VEC_AW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            exp_r    <= {NPINS{1'b0}};
            mask_r   <= {NPINS{1'b0}};
            last_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        Chip_Lat <= Chip_Sel;
                        Vec_Addr <= {VEC_AW{1'b0}};
                        Err_Cnt  <= 8'd0;
                        Fail_Vec <= {VEC_AW{1'b0}};
                        Pass     <= 1'b0;
                        // No chip selected: the run finishes on this very edge
                        Busy     <= (Chip_Sel != 4'd0);
                        Done     <= (Chip_Sel == 4'd0);
                    end
                end
                ST_LOAD: begin
                    Pin_Out <= Vec_Drive;
                    Pin_OE  <= Vec_OE;
                    exp_r   <= Vec_Expect;
                    mask_r  <= Vec_Mask;
                    last_r  <= Vec_Last;
                    cnt_r   <= CNT_INIT;
                end
                ST_SETTLE: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_SAMPLE: begin
                    if (mis_s != {NPINS{1'b0}}) begin
                        Err_Cnt <= err_inc_s;
                        if (Err_Cnt == 8'd0) begin
                            Fail_Vec <= Vec_Addr;
                        end
                    end
                    if (stop_s) begin
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Pin_Out <= {NPINS{1'b0}};
                        Pin_OE  <= {NPINS{1'b0}};
                        // An overrun (index wrapped without last) never passes
                        Pass    <= last_r && (Err_Cnt == 8'd0) && (mis_s == {NPINS{1'b0}});
                    end else begin
                        Vec_Addr <= Vec_Addr + ADDR_ONE;
                    end
                end
                default: begin
                    Busy <= Busy;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_chip_test_sequencer.sv
// Bench for chip_test_sequencer: sync ROM and NAND-style chip model, a run-timeline reference model
// compared every cycle, fixed scenarios with literal expectations, then randomized runs.
module tb_chip_test_sequencer;
    localparam int NP = 16;
    localparam int AW = 5;
    localparam int ST = 4;
    localparam int VC = 3 + ST;
    localparam int NV = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [3:0]    chip_sel;
    logic [3:0]    chip_lat;
    logic [AW-1:0] vec_addr;
    logic [AW-1:0] fail_vec;
    logic [NP-1:0] rom_drv, rom_oe, rom_exp, rom_mask;
    logic          rom_last;
    logic [NP-1:0] pin_in, pin_out, pin_oe;
    logic          busy, done, pass;
    logic [7:0]    err_cnt;
    logic [NP-1:0] fault;

    logic [NP-1:0] t_drv  [16][NV];
    logic [NP-1:0] t_oe   [16][NV];
    logic [NP-1:0] t_exp  [16][NV];
    logic [NP-1:0] t_mask [16][NV];
    logic          t_last [16][NV];

    int n_tests = 0;
    int n_fail  = 0;

    bit            m_valid = 1'b0;
    int            m_mode  = 0;
    int            m_d     = 0;
    int            m_k     = 0;
    logic [3:0]    m_chip  = 4'd0;
    bit            m_ended = 1'b0;
    logic [NP-1:0] m_drv [NV];
    logic [NP-1:0] m_oe  [NV];
    bit            m_mis [NV];

    chip_test_sequencer #(.NPINS(NP), .VEC_AW(AW), .SETTLE(ST)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .Chip_Sel(chip_sel), .Chip_Lat(chip_lat),
        .Vec_Addr(vec_addr), .Vec_Drive(rom_drv), .Vec_OE(rom_oe), .Vec_Expect(rom_exp),
        .Vec_Mask(rom_mask), .Vec_Last(rom_last), .Pin_In(pin_in), .Pin_Out(pin_out),
        .Pin_OE(pin_oe), .Busy(busy), .Done(done), .Pass(pass), .Err_Cnt(err_cnt),
        .Fail_Vec(fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Socketed chip: driven pins read back, others are NAND of the two lower neighbours' drive
    function automatic logic [NP-1:0] nand_fn(input logic [NP-1:0] drv, input logic [NP-1:0] oe,
                                              input logic [NP-1:0] stuck);
        logic [NP-1:0] r1, r2;
        r1 = {drv[NP-2:0], drv[NP-1]};
        r2 = {drv[NP-3:0], drv[NP-1:NP-2]};
        return ((oe & drv) | (~oe & ~(r1 & r2))) & ~stuck;
    endfunction

    assign pin_in = nand_fn(pin_out, pin_oe, fault);

    // Synchronous vector ROM
    always @(posedge clk) begin
        rom_drv  <= t_drv[chip_lat][vec_addr];
        rom_oe   <= t_oe[chip_lat][vec_addr];
        rom_exp  <= t_exp[chip_lat][vec_addr];
        rom_mask <= t_mask[chip_lat][vec_addr];
        rom_last <= t_last[chip_lat][vec_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Work out a whole run up front: vector count, per-vector mismatch, how the table ends
    task automatic start_model(input logic [3:0] c);
        int k;
        m_mode = 1; m_d = 0; m_chip = c; m_k = 0; m_ended = 1'b0;
        if (c != 4'd0) begin
            for (int v = 0; v < NV; v++) begin
                m_drv[v] = t_drv[c][v];
                m_oe[v]  = t_oe[c][v];
                m_mis[v] = (((nand_fn(t_drv[c][v], t_oe[c][v], fault) ^ t_exp[c][v])
                             & t_mask[c][v] & ~t_oe[c][v]) != 16'h0000);
            end
            k = NV;
            for (int v = NV - 1; v >= 0; v--) if (t_last[c][v]) k = v + 1;
`ifdef CHK_STOP_ON_FAIL_EN
            for (int v = k - 1; v >= 0; v--) if (m_mis[v]) k = v + 1;
`endif
            m_k     = k;
            m_ended = t_last[c][k-1];
        end
    endtask

    // Reference model: advance the run timeline by one clock edge
    always @(posedge clk) begin
        if (!reset) begin
            m_mode = 0; m_d = 0; m_k = 0; m_chip = 4'd0; m_valid = 1'b1;
        end else if (start && (m_mode == 0 || m_d >= m_k * VC)) begin
            start_model(chip_sel);
        end else if (m_mode == 1 && m_d < 1000000) begin
            m_d++;
        end
    end

    task automatic compare_all();
        logic [NP-1:0] e_oe, e_out;
        logic [3:0]    e_chip;
        int            e_err, e_fail, e_addr, comp, v;
        bit            e_busy, e_done, e_pass;
        e_oe = 16'h0000; e_out = 16'h0000; e_chip = 4'd0;
        e_err = 0; e_fail = 0; e_addr = 0;
        e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
        if (m_mode == 1) begin
            e_chip = m_chip;
            e_busy = (m_d < m_k * VC);
            e_done = !e_busy;
            if (m_d >= 2 && e_busy) begin
                v = (m_d - 2) / VC;
                e_oe = m_oe[v];
                e_out = m_drv[v];
            end
            comp = m_d / VC;
            if (comp > m_k) comp = m_k;
            for (int i = 0; i < comp; i++) begin
                if (m_mis[i]) begin
                    if (e_err == 0) e_fail = i;
                    if (e_err < 255) e_err++;
                end
            end
            if (m_k > 0) e_addr = (m_d / VC < m_k - 1) ? m_d / VC : m_k - 1;
            e_pass = e_done && m_ended && (e_err == 0);
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("pass", 32'(pass), 32'(e_pass));
        chk("err_cnt", 32'(err_cnt), 32'(e_err));
        chk("fail_vec", 32'(fail_vec), 32'(e_fail));
        chk("vec_addr", 32'(vec_addr), 32'(e_addr));
        chk("chip_lat", 32'(chip_lat), 32'(e_chip));
        chk("pin_oe", 32'(pin_oe), 32'(e_oe));
        chk("pin_out", 32'(pin_out), 32'(e_out));
    endtask

    // Compare DUT outputs with the model on every falling edge
    always @(negedge clk) begin
        if (m_valid) compare_all();
    end

    task automatic build_tables();
        logic [NP-1:0] d1 [4];
        logic [NP-1:0] d2 [4];
        int len;
        d1 = '{16'h00A5, 16'h003C, 16'h00FF, 16'h0000};
        d2 = '{16'h0013, 16'h00C1, 16'h0050, 16'h00A2};
        for (int c = 0; c < 16; c++) begin
            for (int v = 0; v < NV; v++) begin
                t_drv[c][v] = 16'h0000; t_oe[c][v] = 16'h0000; t_exp[c][v] = 16'h0000;
                t_mask[c][v] = 16'h0000; t_last[c][v] = 1'b0;
            end
        end
        for (int v = 0; v < 4; v++) begin
            t_drv[1][v] = d1[v]; t_oe[1][v] = 16'h00FF; t_mask[1][v] = 16'hFFFF;
            t_exp[1][v] = nand_fn(d1[v], 16'h00FF, 16'h0000);
            t_drv[2][v] = d2[v]; t_oe[2][v] = 16'h00F3;
            t_mask[2][v] = (v == 2) ? 16'hFFFF : 16'hFFFB;
            t_exp[2][v] = nand_fn(d2[v], 16'h00F3, 16'h0000);
        end
        t_last[1][3] = 1'b1;
        t_last[2][3] = 1'b1;
        for (int v = 0; v < 8; v++) begin
            t_drv[3][v] = 16'(v * 37); t_oe[3][v] = 16'h00FF; t_mask[3][v] = 16'hFFFF;
            t_exp[3][v] = nand_fn(16'(v * 37), 16'h00FF, 16'h0000) ^ ((v == 1) ? 16'h0100 : 16'h0000);
        end
        t_last[3][7] = 1'b1;
        for (int v = 0; v < NV; v++) begin
            t_drv[4][v] = 16'($urandom); t_oe[4][v] = 16'($urandom); t_mask[4][v] = 16'($urandom);
            t_exp[4][v] = nand_fn(t_drv[4][v], t_oe[4][v], 16'h0000);
        end
        for (int c = 5; c < 16; c++) begin
            len = int'($urandom_range(1, 12));
            for (int v = 0; v < len; v++) begin
                t_drv[c][v] = 16'($urandom); t_oe[c][v] = 16'($urandom); t_mask[c][v] = 16'($urandom);
                t_exp[c][v] = nand_fn(t_drv[c][v], t_oe[c][v], 16'h0000)
                              ^ (($urandom_range(0, 3) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000);
            end
            t_last[c][len-1] = 1'b1;
        end
    endtask

    // Raise Start for 'hold' cycles, then wait (bounded) for Done; cyc counts from the start edge as 1
    task automatic run_wait(input logic [3:0] c, input int hold, output int cyc);
        start = 1'b1;
        chip_sel = c;
        for (int h = 0; h < hold; h++) @(negedge clk);
        start = 1'b0;
        cyc = hold;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            chip_sel = 4'($urandom_range(0, 15));
        end
        if (!done) chk("done_timeout", 32'(done), 1);
    endtask

    initial begin
        int cyc;
        reset = 1'b0; start = 1'b0; chip_sel = 4'd0; fault = 16'h0000;
        build_tables();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_wait(4'd1, 1, cyc);
        chk("t1_cycles", 32'(cyc), 29);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_err", 32'(err_cnt), 0);
        chk("t1_model_k", 32'(m_k), 4);

        fault = 16'h0004;
        run_wait(4'd2, 1, cyc);
        chk("t2_pass", 32'(pass), 0);
        chk("t2_err", 32'(err_cnt), 1);
        chk("t2_fail_vec", 32'(fail_vec), 2);
        chk("t2_model_mis2", 32'(m_mis[2]), 1);
        fault = 16'h0000;

        run_wait(4'd0, 1, cyc);
        chk("t3_cycles", 32'(cyc), 1);
        chk("t3_pass", 32'(pass), 0);
        chk("t3_done", 32'(done), 1);

        run_wait(4'd3, 1, cyc);
`ifdef CHK_STOP_ON_FAIL_EN
        chk("t6_cycles", 32'(cyc), 15);
`else
        chk("t6_cycles", 32'(cyc), 57);
`endif
        chk("t6_err", 32'(err_cnt), 1);
        chk("t6_fail_vec", 32'(fail_vec), 1);
        chk("t6_pass", 32'(pass), 0);

        run_wait(4'd4, 1, cyc);
        chk("t5_cycles", 32'(cyc), 225);
        chk("t5_pass", 32'(pass), 0);
        chk("t5_err", 32'(err_cnt), 0);
        chk("t5_vec_addr", 32'(vec_addr), 31);

        start = 1'b1; chip_sel = 4'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_busy_pre", 32'(busy), 1);
        chk("t4_oe_pre", 32'(pin_oe), 32'h00FF);
        reset = 1'b0;
        @(negedge clk);
        chk("t4_oe", 32'(pin_oe), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_done", 32'(done), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            fault = ($urandom_range(0, 2) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
            run_wait(4'($urandom_range(0, 15)), int'($urandom_range(1, 3)), cyc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
